// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
    localparam int MEM_LAT_DEF = 2;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU, DMA and memory-side signals of the arbiter (dma_err only with DMA_PROT_EN)
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          cpu_req, cpu_we, cpu_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ready;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
`ifdef DMA_PROT_EN
    logic          dma_err;
`endif
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
`ifdef DMA_PROT_EN
        output dma_err,
`endif
        output busy
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
`ifdef DMA_PROT_EN
        input  dma_err,
`endif
        input  busy
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: CPU-priority winner selection with a starvation counter that forces DMA
module mem_arb_pick import mem_arb_pkg::*; #(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   idle,
    input  logic   grant,
    output owner_t winner
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
    assign winner = (dma_req && (!cpu_req || starve_cnt == SW'(STARVE_MAX))) ? OWN_DMA : OWN_CPU;
    // count CPU grants that made a waiting DMA lose; clear once DMA wins or stops asking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (idle && (!dma_req || (grant && winner == OWN_DMA)))
            starve_cnt <= '0;
        else if (grant && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between CPU and DMA; DMA_PROT_EN adds DMA write protection
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
`ifdef DMA_PROT_EN
    , parameter logic [AW-1:0] PROT_LIMIT = AW'(32'h0000_0400)
`endif
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int WCW = $clog2(MEM_LAT + 1);
    arb_state_t    state;
    owner_t        owner, winner;
    logic          we_q, mem_en_q, mem_we_q, cpu_ready_q, dma_ready_q, busy_q;
    logic [AW-1:0] addr_q, sel_addr;
    logic [DW-1:0] wdata_q, rdata_q, sel_wdata;
    logic [WCW-1:0] wait_cnt;
    logic          idle, grant, sel_dma, sel_we, viol;
`ifdef DMA_PROT_EN
    logic          viol_q, err_q;
    assign viol = sel_dma && sel_we && sel_addr < PROT_LIMIT;
    assign bus.dma_err = err_q;
`else
    assign viol = 1'b0;
`endif
    assign idle      = state == IDLE;
    assign grant     = idle && (bus.cpu_req || bus.dma_req);
    assign sel_dma   = winner == OWN_DMA;
    assign sel_we    = sel_dma ? bus.dma_we : bus.cpu_we;
    assign sel_addr  = sel_dma ? bus.dma_addr : bus.cpu_addr;
    assign sel_wdata = sel_dma ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.cpu_rdata = rdata_q;
    assign bus.dma_rdata = rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.dma_ready = dma_ready_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (bus.cpu_req),
        .dma_req (bus.dma_req),
        .idle    (idle),
        .grant   (grant),
        .winner  (winner)
    );
    // issue/wait/done sequencer; strobes are registered so they line up with the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wait_cnt    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DMA_PROT_EN
            viol_q      <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;
`ifdef DMA_PROT_EN
            err_q       <= 1'b0;
`endif
            case (state)
                IDLE: if (grant) begin
                    state    <= ISSUE;
                    owner    <= winner;
                    we_q     <= sel_we;
                    addr_q   <= sel_addr;
                    wdata_q  <= sel_wdata;
                    mem_en_q <= !viol;
                    mem_we_q <= sel_we && !viol;
                    busy_q   <= 1'b1;
`ifdef DMA_PROT_EN
                    viol_q   <= viol;
`endif
                end
                ISSUE: begin
                    state       <= we_q ? DONE : WAIT;
                    wait_cnt    <= WCW'(1);
                    cpu_ready_q <= we_q && owner == OWN_CPU;
                    dma_ready_q <= we_q && owner == OWN_DMA;
`ifdef DMA_PROT_EN
                    err_q       <= viol_q;
`endif
                end
                WAIT: if (wait_cnt == WCW'(MEM_LAT)) begin
                    state       <= DONE;
                    rdata_q     <= bus.mem_rdata;
                    cpu_ready_q <= owner == OWN_CPU;
                    dma_ready_q <= owner == OWN_DMA;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle CPU between two requesters: the CPU control path and a DMA/loader engine.
- Sequences each access through an issue/wait/done FSM for a memory with fixed read latency, and returns a one-cycle ready pulse to the owner.
- Sits between the multicycle datapath's IorD address mux and the memory. The CPU controller holds its current state while cpu_ready is low.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; must be >= 1
- STARVE_MAX, 4, number of consecutive CPU grants with DMA waiting before DMA is forced
- PROT_LIMIT, 32'h0000_0400, DMA write protection boundary (used only with DMA_PROT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  CPU write when 1, read when 0
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  captured read data
- cpu_ready  out  1  one-cycle completion pulse for the CPU
- dma_req / dma_we / dma_addr / dma_wdata  in  1/1/AW/DW  DMA request set, same rules as the CPU set
- dma_rdata  out  DW  captured read data
- dma_ready  out  1  one-cycle completion pulse for the DMA
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in every state except IDLE
- dma_err  out  1  protection violation pulse (DMA_PROT_EN only)

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, owner=CPU, starve_cnt=0, rdata register=0.
  - All outputs 0, including mem_en, mem_we, both ready pulses and busy.
  - An in-flight read is discarded. After reset release, a request still held high is re-arbitrated from IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Request present: latch owner, we, addr and wdata, then go to ISSUE.
- Arbitration, decided in IDLE only:
  - Only one requester: that requester wins.
  - Both requesting: CPU wins unless starve_cnt==STARVE_MAX, in which case DMA wins.
- starve_cnt:
  - +1 on each CPU grant while dma_req=1, saturating at STARVE_MAX.
  - Cleared on a DMA grant, or in any IDLE cycle with dma_req=0.
- ISSUE:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request.
  - Write: next state DONE.
  - Read: next state WAIT with wait_cnt=1.
- WAIT:
  - mem_en=0; mem_addr is held.
  - While wait_cnt<MEM_LAT: wait_cnt+1 each cycle.
  - On the cycle where wait_cnt==MEM_LAT: capture mem_rdata into the rdata register and go to DONE.
- DONE:
  - Owner's ready=1 for exactly this cycle; next state IDLE.
  - cpu_rdata and dma_rdata both show the rdata register, which holds until the next read capture. Writes leave it unchanged.
- Latency from the first IDLE cycle with req high to the ready pulse:
  - write: 2 cycles
  - read: MEM_LAT+2 cycles (4 at default)
- Requester rules:
  - Request inputs must be stable from the req assertion until ready.
  - The requester may drop req or present a new request on the cycle after ready.
  - A req still high in IDLE is treated as a new access.
- A non-owner's request arriving mid-access waits in IDLE arbitration. There is no preemption.
- The memory sees at most one outstanding access. Back-to-back accesses have one IDLE cycle between DONE and the next ISSUE.

Optional Feature:
- Macro: DMA_PROT_EN
- Defined:
  - A DMA write whose latched addr < PROT_LIMIT goes IDLE->ISSUE with mem_en=0 (suppressed), then DONE.
  - In DONE: dma_ready=1 and dma_err=1.
  - DMA reads and all CPU accesses are unaffected.
- Undefined: the dma_err port and the comparison logic are absent; all DMA writes are issued.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, DONE)
  - owner_t enum (OWN_CPU, OWN_DMA)
  - default MEM_LAT and STARVE_MAX constants
- Sub-module mem_arb_pick: combinational winner selection plus the starve_cnt register. Inputs: cpu_req, dma_req, grant strobe. Output: winner.
- The FSM, wait counter and datapath latches stay in the top level.

Test Plan:
- CPU read, addr 0x10, mem returns 0xDEADBEEF at MEM_LAT=2 -> mem_en at cycle 1; cpu_ready at cycle 4; cpu_rdata=0xDEADBEEF; dma_ready stays 0.
- DMA write, addr 0x800, data 0x55 -> mem_en=mem_we=1 with addr 0x800 and data 0x55 at cycle 1; dma_ready at cycle 2; busy low at cycle 3.
- CPU and DMA request continuously, STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,DMA, then the pattern repeats; starve_cnt is 0 after each DMA grant.
- Async reset pulled low during the WAIT of a CPU read -> all outputs 0 immediately; after release with cpu_req held, a fresh ISSUE occurs and a ready pulse follows 4 cycles later.
- Write then immediate read from the same requester -> one IDLE cycle between DONE and the next ISSUE; the read returns the newly written value from the memory model.
- With DMA_PROT_EN, DMA write to 0x100 -> mem_en stays 0; dma_ready=dma_err=1 at cycle 2. A write to 0x400 issues normally with dma_err=0.
